// File: rtl/cpu_joypad_port.sv
// NES controller port responder at $4016/$4017: a shared strobe latch plus two
// 8-bit button shift registers, each with a saturating read counter.
module cpu_joypad_port #(
    parameter logic [15:0] ADDR_PORT1  = 16'h4016,
    parameter logic [15:0] ADDR_PORT2  = 16'h4017,
    parameter logic [2:0]  OPEN_BUS_HI = 3'b010,
    parameter logic        FILL_BIT    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic        i_rw,
    input  logic [15:0] i_address,
    input  logic [7:0]  i_data,
    input  logic [7:0]  i_buttons_1,
    input  logic [7:0]  i_buttons_2,
    output logic [7:0]  o_data,
    output logic        o_cs,
    output logic        o_strobe,
    output logic [3:0]  o_debug_count_1,
    output logic [3:0]  o_debug_count_2
);

    logic       strobe_q,  strobe_d;
    logic [7:0] shift_1_q, shift_1_d;
    logic [7:0] shift_2_q, shift_2_d;
    logic [3:0] count_1_q, count_1_d;
    logic [3:0] count_2_q, count_2_d;

    logic sel_1_s, sel_2_s, read_1_s, read_2_s;

    assign sel_1_s  = (i_address == ADDR_PORT1);
    assign sel_2_s  = (i_address == ADDR_PORT2);
    assign read_1_s = i_rw & sel_1_s;
    assign read_2_s = i_rw & sel_2_s;

    // Read data steering: the serial bit of the addressed port, zero otherwise.
    always_comb begin
        o_cs   = read_1_s | read_2_s;
        o_data = 8'h00;
        if (read_1_s) begin
            o_data = {OPEN_BUS_HI, 4'b0000, shift_1_q[0]};
        end else if (read_2_s) begin
            o_data = {OPEN_BUS_HI, 4'b0000, shift_2_q[0]};
        end else begin
            o_data = 8'h00;
        end
    end

    // Next state: load uses the registered strobe, so a write only takes effect next edge.
    always_comb begin
        strobe_d  = strobe_q;
        shift_1_d = shift_1_q;
        shift_2_d = shift_2_q;
        count_1_d = count_1_q;
        count_2_d = count_2_q;
        if (i_clk_en) begin
            if (!i_rw && sel_1_s) begin
                strobe_d = i_data[0];
            end else begin
                strobe_d = strobe_q;
            end
            if (strobe_q) begin
                shift_1_d = i_buttons_1;
                shift_2_d = i_buttons_2;
                count_1_d = 4'd0;
                count_2_d = 4'd0;
            end else begin
                if (read_1_s) begin
                    shift_1_d = {FILL_BIT, shift_1_q[7:1]};
                    count_1_d = (count_1_q == 4'd8) ? 4'd8 : count_1_q + 4'd1;
                end else begin
                    shift_1_d = shift_1_q;
                    count_1_d = count_1_q;
                end
                if (read_2_s) begin
                    shift_2_d = {FILL_BIT, shift_2_q[7:1]};
                    count_2_d = (count_2_q == 4'd8) ? 4'd8 : count_2_q + 4'd1;
                end else begin
                    shift_2_d = shift_2_q;
                    count_2_d = count_2_q;
                end
            end
        end else begin
            strobe_d = strobe_q;
        end
    end

    // State registers; reset wins over the clock enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            strobe_q  <= 1'b0;
            shift_1_q <= 8'hFF;
            shift_2_q <= 8'hFF;
            count_1_q <= 4'd0;
            count_2_q <= 4'd0;
        end else begin
            strobe_q  <= strobe_d;
            shift_1_q <= shift_1_d;
            shift_2_q <= shift_2_d;
            count_1_q <= count_1_d;
            count_2_q <= count_2_d;
        end
    end

    assign o_strobe        = strobe_q;
    assign o_debug_count_1 = count_1_q;
    assign o_debug_count_2 = count_2_q;

endmodule

// File: tb/tb_cpu_joypad_port.sv
// Bench for cpu_joypad_port: directed bus cycles push expected read bytes into a
// queue; a monitor pops and compares whenever the port presents read data.
module tb_cpu_joypad_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  btn_1;
    logic [7:0]  btn_2;
    logic [7:0]  rdata;
    logic        cs;
    logic        strobe;
    logic [3:0]  cnt_1;
    logic [3:0]  cnt_2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    cpu_joypad_port dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_clk_en        (clk_en),
        .i_rw            (rw),
        .i_address       (addr),
        .i_data          (wdata),
        .i_buttons_1     (btn_1),
        .i_buttons_2     (btn_2),
        .o_data          (rdata),
        .o_cs            (cs),
        .o_strobe        (strobe),
        .o_debug_count_1 (cnt_1),
        .o_debug_count_2 (cnt_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rw    = 1'b1;
        addr  = 16'h0000;
        wdata = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_idle();
        step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        rw    = 1'b0;
        addr  = a;
        wdata = d;
        step();
        set_idle();
    endtask

    // Read of a matching port: expected bit is hand-computed by the caller.
    task automatic rd(input logic [15:0] a, input logic b);
        exp_q.push_back({3'b010, 4'b0000, b});
        rw   = 1'b1;
        addr = a;
        step();
        set_idle();
    endtask

    // Monitor: every enabled read cycle presented by the port is scored.
    always @(negedge clk) begin
        if (cs && clk_en && !rst) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got %h expected none", rdata);
            end else begin
                chk("read_data", rdata, exp_q.pop_front());
            end
        end
    end

    logic [9:0] seq_bits;

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        btn_1  = 8'h00;
        btn_2  = 8'h00;
        set_idle();
        step();
        step();
        rst = 1'b0;
        chk("reset_strobe", {7'd0, strobe}, 8'h00);
        chk("reset_cnt1", {4'd0, cnt_1}, 8'h00);
        chk("reset_cnt2", {4'd0, cnt_2}, 8'h00);
        chk("idle_cs", {7'd0, cs}, 8'h00);
        chk("idle_data", rdata, 8'h00);

        // Read without strobe returns bit 1 from reset value 8'hFF.
        rd(16'h4016, 1'b1);
        chk("first_read_cnt1", {4'd0, cnt_1}, 8'h01);

        // Load 1000_0101 then shift ten times: 1,0,1,0,0,0,0,1, then fill 1,1.
        btn_1 = 8'b1000_0101;
        wr(16'h4016, 8'h01);
        idle();
        wr(16'h4016, 8'h00);
        chk("after_load_cnt1", {4'd0, cnt_1}, 8'h00);
        seq_bits = 10'b11_1000_0101;
        for (int i = 0; i < 10; i++) begin
            rd(16'h4016, seq_bits[i]);
        end
        chk("saturate_cnt1", {4'd0, cnt_1}, 8'h08);

        // Strobe held high: reads follow current A and never advance.
        btn_1 = 8'h00;
        wr(16'h4016, 8'hFF);
        chk("strobe_set", {7'd0, strobe}, 8'h01);
        idle();
        rd(16'h4016, 1'b0);
        btn_1 = 8'h01;
        idle();
        rd(16'h4016, 1'b1);
        rd(16'h4016, 1'b1);
        btn_1 = 8'h00;
        idle();
        rd(16'h4016, 1'b0);
        chk("held_cnt1", {4'd0, cnt_1}, 8'h00);
        wr(16'h4016, 8'hFE);

        // Interleaved ports.
        btn_1 = 8'h01;
        btn_2 = 8'h02;
        wr(16'h4016, 8'h01);
        idle();
        wr(16'h4016, 8'h00);
        chk("strobe_clear", {7'd0, strobe}, 8'h00);
        rd(16'h4017, 1'b0);
        rd(16'h4016, 1'b1);
        rd(16'h4017, 1'b1);
        chk("inter_cnt2", {4'd0, cnt_2}, 8'h02);
        chk("inter_cnt1", {4'd0, cnt_1}, 8'h01);

        // Write to $4017 ignored; unmapped read; clock enable low.
        wr(16'h4017, 8'h01);
        chk("w4017_strobe", {7'd0, strobe}, 8'h00);
        idle();
        chk("w4017_no_load_cnt1", {4'd0, cnt_1}, 8'h01);
        rw   = 1'b1;
        addr = 16'h4020;
        #1;
        chk("unmapped_cs", {7'd0, cs}, 8'h00);
        chk("unmapped_data", rdata, 8'h00);
        step();
        chk("unmapped_cnt1", {4'd0, cnt_1}, 8'h01);
        clk_en = 1'b0;
        addr   = 16'h4016;
        #1;
        chk("noen_cs", {7'd0, cs}, 8'h01);
        chk("noen_data", rdata, 8'h40);
        for (int i = 0; i < 3; i++) step();
        chk("noen_cnt1", {4'd0, cnt_1}, 8'h01);
        chk("noen_cnt2", {4'd0, cnt_2}, 8'h02);
        chk("noen_data_hold", rdata, 8'h40);
        rw = 1'b0;
        wdata = 8'h01;
        step();
        chk("noen_write_strobe", {7'd0, strobe}, 8'h00);
        set_idle();
        clk_en = 1'b1;

        // Reset after three shifts; reset wins over a disabled clock enable.
        btn_1 = 8'h00;
        wr(16'h4016, 8'h01);
        idle();
        wr(16'h4016, 8'h00);
        rd(16'h4016, 1'b0);
        rd(16'h4016, 1'b0);
        rd(16'h4016, 1'b0);
        chk("pre_reset_cnt1", {4'd0, cnt_1}, 8'h03);
        wr(16'h4016, 8'h01);
        rst    = 1'b1;
        clk_en = 1'b0;
        step();
        rst    = 1'b0;
        clk_en = 1'b1;
        chk("post_reset_strobe", {7'd0, strobe}, 8'h00);
        chk("post_reset_cnt1", {4'd0, cnt_1}, 8'h00);
        chk("post_reset_cnt2", {4'd0, cnt_2}, 8'h00);
        rd(16'h4016, 1'b1);
        idle();

        chk("scoreboard_drained", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
